// File: rtl/instr_fetch_agent_if.sv
// rtl/instr_fetch_agent_if.sv - OBI instruction bus plus consumer stream bundle for instr_fetch_agent
//
// Purpose: groups the instruction-memory request/response signals and the
// fetched-instruction consumer stream into one bundle.
// Modports:
//   master - the fetch agent: drives instr_req/instr_addr and out_* data,
//            receives instr_gnt/instr_rvalid/instr_rdata/instr_err and out_ready_i.
//   slave  - the memory/consumer side: the mirror image of master.
interface instr_fetch_agent_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        instr_err;

  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_addr_o;
  logic [31:0] out_rdata_o;
  logic        out_err_o;

  modport master (
    output instr_req, instr_addr,
    input  instr_gnt, instr_rvalid, instr_rdata, instr_err,
    output out_valid_o, out_addr_o, out_rdata_o, out_err_o,
    input  out_ready_i
  );

  modport slave (
    input  instr_req, instr_addr,
    output instr_gnt, instr_rvalid, instr_rdata, instr_err,
    input  out_valid_o, out_addr_o, out_rdata_o, out_err_o,
    output out_ready_i
  );
endinterface

// File: rtl/instr_fetch_agent.sv
// rtl/instr_fetch_agent.sv - sequential instruction prefetcher with redirect flush and response buffer
//
// Purpose: issues word-aligned sequential OBI fetches, tracks granted requests
// in order, buffers responses in a small FIFO and streams them to a consumer.
// A redirect flushes the buffer and drops every response still owed by the
// memory for the old stream.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_i, start_addr_i      pulse: begin fetching at start_addr_i (IDLE only)
//   redirect_i, redirect_addr_i pulse: flush and refetch from redirect_addr_i
//   halt_i                     level: stop issuing new requests
//   bus                        instruction bus + consumer stream (master side)
//   busy_o                     running, or responses still outstanding
//   proto_err_o                sticky: unexpected rvalid or grant without request
module instr_fetch_agent #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [31:0]                start_addr_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_addr_i,
  input  logic                       halt_i,
  instr_fetch_agent_if.master        bus,
  output logic                       busy_o,
  output logic                       proto_err_o
);

  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int PAW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int SW  = ((OW > CW) ? OW : CW) + 1;

  localparam logic [OW-1:0] MAX_O   = OW'(MAX_OUTST);
  localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_n;
  logic            req_q;
  logic [31:0]     addr_q;
  logic [31:0]     next_addr;
  logic [OW-1:0]   outst, outst_n;
  logic [OW-1:0]   discard, discard_n;
  logic [CW-1:0]   fcnt, fcnt_n;
  logic [FAW-1:0]  frd, fwr;
  logic [PAW-1:0]  prd, pwr;
  logic            proto_q;

  // pending-address queue (granted, response not yet seen) and response FIFO
  logic [31:0]     pq_mem [MAX_OUTST];
  logic [31:0]     f_addr [FIFO_DEPTH];
  logic [31:0]     f_data [FIFO_DEPTH];
  logic            f_err  [FIFO_DEPTH];

  logic            gnt_fire, rv_ok, pending_after;
  logic            push, pop, issue, out_valid;
  logic [31:0]     nxt_base;
  logic [SW-1:0]   credit_sum;

  function automatic logic [PAW-1:0] pq_inc(input logic [PAW-1:0] p);
    return (p == PAW'(MAX_OUTST - 1)) ? '0 : p + PAW'(1);
  endfunction

  assign out_valid = (fcnt != '0);

  always_comb begin
    gnt_fire      = req_q & bus.instr_gnt;
    // an rvalid with nothing outstanding is a protocol error and is ignored
    rv_ok         = bus.instr_rvalid & (outst != '0);
    pending_after = req_q & ~bus.instr_gnt;

    outst_n = outst;
    if (gnt_fire && !rv_ok)      outst_n = outst + OW'(1);
    else if (!gnt_fire && rv_ok) outst_n = outst - OW'(1);

    // a response landing in the redirect cycle belongs to the old stream
    push = rv_ok & (discard == '0) & ~redirect_i;
    pop  = out_valid & bus.out_ready_i;

    fcnt_n = fcnt;
    if (redirect_i)          fcnt_n = '0;
    else if (push && !pop)   fcnt_n = fcnt + CW'(1);
    else if (!push && pop)   fcnt_n = fcnt - CW'(1);

    // everything still owed by memory after this cycle, including a request
    // that is on the bus but not yet granted, belongs to the old stream
    discard_n = discard;
    if (redirect_i)                  discard_n = outst_n + OW'(pending_after);
    else if (rv_ok && discard != '0) discard_n = discard - OW'(1);

    state_n = state;
    case (state)
      IDLE:    if (start_i || redirect_i) state_n = RUN;
      RUN:     if (halt_i && !pending_after) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    nxt_base = next_addr;
    if (redirect_i)                    nxt_base = redirect_addr_i & ~32'd3;
    else if (state == IDLE && start_i) nxt_base = start_addr_i & ~32'd3;

    // credit is judged on post-update counts so every granted request
    // already owns a FIFO slot
    credit_sum = SW'(outst_n) + SW'(fcnt_n);
    issue = ~pending_after & (state_n == RUN) & ~halt_i &
            (outst_n < MAX_O) & (credit_sum < DEPTH_S);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      next_addr <= '0;
      outst     <= '0;
      discard   <= '0;
      fcnt      <= '0;
      frd       <= '0;
      fwr       <= '0;
      prd       <= '0;
      pwr       <= '0;
      proto_q   <= 1'b0;
    end else begin
      state   <= state_n;
      req_q   <= pending_after | issue;
      outst   <= outst_n;
      discard <= discard_n;
      fcnt    <= fcnt_n;
      if (issue) begin
        addr_q    <= nxt_base;
        next_addr <= nxt_base + 32'd4;
      end else begin
        next_addr <= nxt_base;
      end
      if (gnt_fire) pwr <= pq_inc(pwr);
      if (rv_ok)    prd <= pq_inc(prd);
      if (redirect_i) begin
        frd <= '0;
        fwr <= '0;
      end else begin
        if (push) fwr <= fwr + FAW'(1);
        if (pop)  frd <= frd + FAW'(1);
      end
      if ((bus.instr_rvalid && outst == '0) || (bus.instr_gnt && !req_q))
        proto_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_fire) pq_mem[pwr] <= addr_q;
    if (push) begin
      f_addr[fwr] <= pq_mem[prd];
      f_data[fwr] <= bus.instr_rdata;
      f_err[fwr]  <= bus.instr_err;
    end
  end

  assign bus.instr_req   = req_q;
  assign bus.instr_addr  = addr_q;
  assign bus.out_valid_o = out_valid;
  assign bus.out_addr_o  = out_valid ? f_addr[frd] : '0;
  assign bus.out_rdata_o = out_valid ? f_data[frd] : '0;
  assign bus.out_err_o   = out_valid & f_err[frd];
  assign busy_o          = (state == RUN) || (outst != '0);
  assign proto_err_o     = proto_q;

endmodule

// File: tb/tb_instr_fetch_agent.sv
// tb/tb_instr_fetch_agent.sv - self-checking bench for instr_fetch_agent
//
// Purpose: directed scenarios plus a randomized run; a memory model answers
// grants in order, and the consumer side expects a contiguous address stream
// restarting at each start/redirect target.
module tb_instr_fetch_agent;
  localparam int FD = 4;
  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] start_addr_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic        halt_i = 1'b0;
  logic        busy;
  logic        proto_err;

  instr_fetch_agent_if bus();

  instr_fetch_agent #(.FIFO_DEPTH(FD), .MAX_OUTST(MO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .start_addr_i    (start_addr_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .halt_i          (halt_i),
    .bus             (bus),
    .busy_o          (busy),
    .proto_err_o     (proto_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned gnt_pct, rv_pct, rdy_pct;
  logic [31:0] mem_q[$];
  logic [31:0] exp_addr;
  logic [31:0] err_at;
  int          n_gnt, n_deliv, n_err_seen;
  logic        prev_wait;
  logic [31:0] prev_addr;
  logic [31:0] held;
  int          d0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Entered and left at a falling edge; drives one rising edge worth of inputs.
  task automatic cycle();
    logic [31:0] head;
    bus.instr_gnt = bus.instr_req && ($urandom_range(99) < gnt_pct);
    if (mem_q.size() > 0 && $urandom_range(99) < rv_pct) begin
      head = mem_q.pop_front();
      bus.instr_rvalid = 1'b1;
      bus.instr_rdata  = data_of(head);
      bus.instr_err    = (head == err_at);
    end else begin
      bus.instr_rvalid = 1'b0;
      bus.instr_rdata  = $urandom;
      bus.instr_err    = 1'b0;
    end
    bus.out_ready_i = ($urandom_range(99) < rdy_pct);
    if (bus.out_valid_o && bus.out_ready_i) begin
      chk("out_addr", bus.out_addr_o, exp_addr);
      chk("out_rdata", bus.out_rdata_o, data_of(exp_addr));
      chk("out_err", 32'(bus.out_err_o), 32'(exp_addr == err_at));
      if (bus.out_err_o) n_err_seen++;
      exp_addr = exp_addr + 32'd4;
      n_deliv++;
    end
    if (redirect_i) exp_addr = redirect_addr_i & ~32'd3;
    if (bus.instr_gnt) begin
      chk("aligned", 32'(bus.instr_addr[1:0]), 32'd0);
      mem_q.push_back(bus.instr_addr);
      n_gnt++;
    end
    prev_wait = bus.instr_req && !bus.instr_gnt;
    prev_addr = bus.instr_addr;
    @(posedge clk);
    @(negedge clk);
    start_i    = 1'b0;
    redirect_i = 1'b0;
    if (prev_wait) begin
      chk("req_hold", 32'(bus.instr_req), 32'd1);
      chk("addr_hold", bus.instr_addr, prev_addr);
    end
  endtask

  task automatic apply_reset(input bit do_chk);
    rst_n = 1'b0;
    start_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0;
    bus.instr_gnt = 1'b0; bus.instr_rvalid = 1'b0;
    bus.instr_rdata = '0; bus.instr_err = 1'b0; bus.out_ready_i = 1'b0;
    mem_q.delete();
    n_gnt = 0; n_deliv = 0; n_err_seen = 0; prev_wait = 1'b0;
    repeat (3) @(negedge clk);
    if (do_chk) begin
      chk("rst_req", 32'(bus.instr_req), 32'd0);
      chk("rst_addr", bus.instr_addr, 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      chk("rst_out_addr", bus.out_addr_o, 32'd0);
      chk("rst_out_rdata", bus.out_rdata_o, 32'd0);
      chk("rst_out_err", 32'(bus.out_err_o), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_proto", 32'(proto_err), 32'd0);
    end
    rst_n = 1'b1;
  endtask

  task automatic do_start(input logic [31:0] a);
    start_i = 1'b1;
    start_addr_i = a;
    exp_addr = a & ~32'd3;
    cycle();
  endtask

  initial begin
    err_at = 32'h1;
    apply_reset(1'b1);

    // back-to-back grant/response, full throughput
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    do_start(32'h8000_0000);
    repeat (10) cycle();
    d0 = n_deliv;
    repeat (16) cycle();
    chk("throughput", 32'(n_deliv - d0), 32'd16);
    chk("busy_run", 32'(busy), 32'd1);

    // error response for 0x8000_0008 only, fetching continues past it
    apply_reset(1'b0);
    err_at = 32'h8000_0008;
    gnt_pct = 75; rv_pct = 75; rdy_pct = 75;
    do_start(32'h8000_0000);
    repeat (60) cycle();
    chk("err_count", 32'(n_err_seen), 32'd1);
    chk("err_continue", 32'(exp_addr >= 32'h8000_0010), 32'd1);
    err_at = 32'h1;

    // stalled consumer: credit limits to FIFO_DEPTH grants
    apply_reset(1'b0);
    gnt_pct = 100; rv_pct = 100; rdy_pct = 0;
    do_start(32'h0000_1000);
    repeat (20) cycle();
    chk("credit_grants", 32'(n_gnt), 32'd4);
    chk("credit_req_off", 32'(bus.instr_req), 32'd0);
    chk("credit_proto", 32'(proto_err), 32'd0);
    chk("credit_full", 32'(bus.out_valid_o), 32'd1);
    rdy_pct = 100;
    repeat (12) cycle();
    chk("credit_drain", 32'(n_deliv >= 8), 32'd1);

    // redirect with two responses outstanding
    rv_pct = 0;
    repeat (6) cycle();
    chk("two_outst", 32'(mem_q.size()), 32'd2);
    chk("outst_req_off", 32'(bus.instr_req), 32'd0);
    redirect_i = 1'b1; redirect_addr_i = 32'h0000_2003;
    cycle();
    rv_pct = 100;
    d0 = n_deliv;
    repeat (10) cycle();
    chk("redir_flow", 32'(n_deliv - d0 >= 5), 32'd1);

    // redirect while a request waits for its grant
    gnt_pct = 0;
    repeat (6) cycle();
    chk("wait_req", 32'(bus.instr_req), 32'd1);
    held = bus.instr_addr;
    redirect_i = 1'b1; redirect_addr_i = 32'h0000_4000;
    cycle();
    repeat (7) cycle();
    chk("wait_addr", bus.instr_addr, held);
    gnt_pct = 100;
    d0 = n_deliv;
    repeat (12) cycle();
    chk("wait_flow", 32'(n_deliv - d0 >= 4), 32'd1);

    // halt drains to idle; redirect from idle resumes and wraps the address
    halt_i = 1'b1;
    repeat (12) cycle();
    chk("halt_req", 32'(bus.instr_req), 32'd0);
    chk("halt_busy", 32'(busy), 32'd0);
    halt_i = 1'b0;
    repeat (3) cycle();
    chk("idle_req", 32'(bus.instr_req), 32'd0);
    redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFF0;
    cycle();
    repeat (20) cycle();
    chk("wrap", 32'(exp_addr < 32'h0000_0100), 32'd1);

    // randomized traffic with random redirects
    apply_reset(1'b0);
    gnt_pct = 80; rv_pct = 70; rdy_pct = 70;
    do_start(32'hFFFF_FFE2);
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        gnt_pct = $urandom_range(100, 20);
        rv_pct  = $urandom_range(100, 20);
        rdy_pct = $urandom_range(100, 10);
      end
      if ($urandom_range(99) < 2) begin
        redirect_i = 1'b1;
        redirect_addr_i = $urandom;
      end
      cycle();
    end
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    repeat (20) cycle();
    chk("rand_proto", 32'(proto_err), 32'd0);
    chk("rand_deliv", 32'(n_deliv > 100), 32'd1);

    // stray response with nothing outstanding
    apply_reset(1'b0);
    bus.instr_rvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.instr_rvalid = 1'b0;
    chk("proto_set", 32'(proto_err), 32'd1);
    repeat (5) cycle();
    chk("proto_sticky", 32'(proto_err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("proto_clear", 32'(proto_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
